// File: rtl/store_access_arbiter.sv
// Round-robin arbiter between one write and one read requester sharing a
// synchronous 4-entry store; writes can be refused while lockDown is high.
`timescale 1ns/1ps
module store_access_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic              lockDown,
  output logic              wrGrant,
  output logic              wrDenied,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0] address,
  output logic              shouldWrite,
  output logic [DATA_W-1:0] inputData,
  input  logic [DATA_W-1:0] outputData,
  output logic [2:0]        dbgState
);

  // Handshake: a requester raises its req with address/data stable and keeps
  // them until its one-cycle completion pulse (wrGrant/wrDenied or rdValid).
  // Requests are only looked at in IDLE; a req still high there is a new one.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_DENY  = 3'd2,
    S_READ  = 3'd3,
    S_WAIT  = 3'd4,
    S_RDONE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                last_wr_q, last_wr_d;
  logic                pick_wr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      last_wr_q <= last_wr_d;
    end
  end

  // The writer wins unless both request and the writer was served last.
  assign pick_wr = wrReq && !(rdReq && last_wr_q);

  always_comb begin
    state_d   = S_IDLE;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    last_wr_d = last_wr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_wr) begin
          addr_d    = wrAddr;
          data_d    = wrData;
          last_wr_d = 1'b1;
          state_d   = lockDown ? S_DENY : S_WRITE;
        end else if (rdReq) begin
          addr_d    = rdAddr;
          last_wr_d = 1'b0;
          state_d   = S_READ;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_DENY:  state_d = S_IDLE;
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        rd_data_d = outputData;
        state_d   = S_RDONE;
      end
      S_RDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode the registered state so reset removes them immediately.
  assign shouldWrite = (state_q == S_WRITE);
  assign wrGrant     = (state_q == S_WRITE);
  assign wrDenied    = (state_q == S_DENY);
  assign rdValid     = (state_q == S_RDONE);
  assign rdData      = rd_data_q;
  assign address     = addr_q;
  assign inputData   = data_q;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_store_access_arbiter.sv
// Directed bench for store_access_arbiter with a behavioural synchronous store.
`timescale 1ns/1ps
module tb_store_access_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       wrReq = 1'b0;
  logic [1:0] wrAddr = '0;
  logic [3:0] wrData = '0;
  logic       rdReq = 1'b0;
  logic [1:0] rdAddr = '0;
  logic       lockDown = 1'b0;
  logic       wrGrant, wrDenied, rdValid, shouldWrite;
  logic [3:0] rdData, inputData, outputData;
  logic [1:0] address;
  logic [2:0] dbgState;

  logic [3:0] mem [4];
  logic [3:0] exp_mem [4];

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_wr;
    bit         lock;
    logic [1:0] addr;
    logic [3:0] data;
    bit         exp_deny;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];

  // clock / reset
  always #5 CLK = ~CLK;

  store_access_arbiter #(.DATA_W(4), .ADDR_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData),
    .rdReq(rdReq), .rdAddr(rdAddr), .lockDown(lockDown),
    .wrGrant(wrGrant), .wrDenied(wrDenied), .rdValid(rdValid), .rdData(rdData),
    .address(address), .shouldWrite(shouldWrite), .inputData(inputData),
    .outputData(outputData), .dbgState(dbgState)
  );

  // synchronous store: write on edge, read data one edge after address
  always @(posedge CLK) begin
    if (shouldWrite) mem[address] <= inputData;
    outputData <= mem[address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input bit lock, input bit exp_deny);
    int n;
    @(negedge CLK);
    wrReq = 1'b1; wrAddr = a; wrData = d; lockDown = lock;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(wrGrant || wrDenied) && n < 8);
    check("wr_latency", n, 1);
    check("wr_grant", wrGrant, !exp_deny);
    check("wr_denied", wrDenied, exp_deny);
    check("wr_should_write", shouldWrite, !exp_deny);
    if (!exp_deny) begin
      check("wr_address", address, a);
      check("wr_input_data", inputData, d);
      exp_mem[a] = d;
    end
    wrReq = 1'b0; lockDown = 1'b0;
    @(negedge CLK);
    check("wr_pulse_end", {wrGrant, wrDenied, shouldWrite}, 3'b000);
    check("wr_idle", dbgState, 0);
    check("wr_store", mem[a], exp_mem[a]);
  endtask

  task automatic do_read(input logic [1:0] a, input bit lock, input logic [3:0] exp_rd);
    int n;
    @(negedge CLK);
    rdReq = 1'b1; rdAddr = a; lockDown = lock;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!rdValid && n < 10);
    check("rd_latency", n, 3);
    check("rd_data", rdData, exp_rd);
    rdReq = 1'b0; lockDown = 1'b0;
    @(negedge CLK);
    check("rd_pulse_end", rdValid, 0);
    check("rd_idle", dbgState, 0);
  endtask

  initial begin
    int k;
    int last;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 4'(i + 8);
      exp_mem[i] = 4'(i + 8);
    end

    //           wr lock addr data deny rd
    vecs[0]  = '{1, 0, 2'd2, 4'h7, 0, 4'h0};
    vecs[1]  = '{0, 0, 2'd2, 4'h0, 0, 4'h7};
    vecs[2]  = '{1, 1, 2'd1, 4'h5, 1, 4'h0};
    vecs[3]  = '{0, 0, 2'd1, 4'h0, 0, 4'h9};
    vecs[4]  = '{1, 0, 2'd0, 4'h3, 0, 4'h0};
    vecs[5]  = '{0, 0, 2'd0, 4'h0, 0, 4'h3};
    vecs[6]  = '{1, 0, 2'd3, 4'hF, 0, 4'h0};
    vecs[7]  = '{0, 0, 2'd3, 4'h0, 0, 4'hF};
    vecs[8]  = '{1, 1, 2'd3, 4'h0, 1, 4'h0};
    vecs[9]  = '{0, 1, 2'd3, 4'h0, 0, 4'hF};
    vecs[10] = '{0, 1, 2'd2, 4'h0, 0, 4'h7};

    // reset state
    #12;
    check("rst_state", dbgState, 0);
    check("rst_strobes", {shouldWrite, wrGrant, wrDenied, rdValid}, 4'b0000);
    check("rst_address", address, 0);
    check("rst_input_data", inputData, 0);
    check("rst_rd_data", rdData, 0);
    @(negedge CLK);
    RST = 1'b1;

    // table-driven single transactions
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].lock, vecs[i].exp_deny);
      else               do_read(vecs[i].addr, vecs[i].lock, vecs[i].exp_rd);
    end

    // tie from reset: read first, then alternate; entries = cycle*4 + {wrGrant,rdValid}
    do_reset();
    wrReq = 1'b1; wrAddr = 2'd1; wrData = 4'h6; lockDown = 1'b0;
    rdReq = 1'b1; rdAddr = 2'd2;
    exp_q = '{3*4+1, 5*4+2, 9*4+1, 11*4+2};
    obs_q = {};
    for (int n = 1; n <= 11; n++) begin
      @(negedge CLK);
      if (wrGrant || rdValid) obs_q.push_back(32'(n * 4) + {30'd0, wrGrant, rdValid});
      if (rdValid) check("tie_rd_data", rdData, 4'h7);
    end
    wrReq = 1'b0; rdReq = 1'b0;
    exp_mem[1] = 4'h6;
    check("tie_event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("tie_event", obs_q[i], exp_q[i]);
    @(negedge CLK);
    check("tie_store", mem[1], exp_mem[1]);

    // reset during WRITE aborts the store update
    @(negedge CLK);
    wrReq = 1'b1; wrAddr = 2'd0; wrData = 4'hE;
    @(negedge CLK);
    check("abort_in_write", {dbgState, shouldWrite}, {3'd1, 1'b1});
    #1 RST = 1'b0;
    #1;
    check("abort_should_write", shouldWrite, 0);
    check("abort_state", dbgState, 0);
    check("abort_strobes", {wrGrant, wrDenied, rdValid}, 3'b000);
    check("abort_address", address, 0);
    @(negedge CLK);
    wrReq = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_no_grant", wrGrant, 0);
    check("abort_store", mem[0], exp_mem[0]);

    // lockDown raised after acceptance does not turn the write into a denial
    @(negedge CLK);
    wrReq = 1'b1; wrAddr = 2'd2; wrData = 4'h4; lockDown = 1'b0;
    @(posedge CLK);
    #1 lockDown = 1'b1;
    @(negedge CLK);
    check("late_lock_grant", {wrGrant, wrDenied, shouldWrite}, 3'b101);
    wrReq = 1'b0; lockDown = 1'b0;
    exp_mem[2] = 4'h4;
    @(negedge CLK);
    check("late_lock_store", mem[2], exp_mem[2]);

    // back-to-back reads with rdReq held
    @(negedge CLK);
    rdReq = 1'b1; rdAddr = 2'd0;
    k = 0;
    last = 0;
    for (int n = 1; n <= 30 && k < 4; n++) begin
      @(negedge CLK);
      if (rdValid) begin
        check("b2b_data", rdData, exp_mem[k]);
        check("b2b_spacing", n - last, (k == 0) ? 3 : 4);
        last = n;
        k++;
        if (k < 4) rdAddr = 2'(k);
        else       rdReq = 1'b0;
      end
    end
    rdReq = 1'b0;
    check("b2b_count", k, 4);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
